usb_rx_pkt: RTL
===============

Name: usb_rx_pkt

Overview:
Packet-level receive controller sitting between the bit-level USB receiver and the SIE endpoint logic. Consumes the byte stream (data/valid/active/error) from the receiver, checks PID and PID complement, and classifies the packet. Extracts token and SOF fields and streams DATA payload with the two CRC16 bytes stripped. Checks CRC5/CRC16 and reports a single end-of-packet status pulse per packet.

Parameters:
MAX_PAYLOAD, 1023, max DATA payload bytes accepted; longer sets err_len

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
rx_data  input  8  byte from receiver, LSB first on wire
rx_valid  input  1  one-cycle pulse, rx_data valid
rx_active  input  1  high between SYNC and EOP
rx_error  input  1  receiver error (bit-stuff/abort)
pid  output  4  PID of current/last packet (low nibble)
tok_addr  output  7  token address (IN/OUT/SETUP)
tok_endp  output  4  token endpoint
frame_no  output  11  SOF frame number
tok_valid  output  1  pulse: token/SOF fields valid and CRC5 good
pl_data  output  8  payload byte
pl_valid  output  1  pulse per payload byte
pkt_end  output  1  pulse at end of every packet
pkt_ok  output  1  qualifies pkt_end: no error
err_pid  output  1  status with pkt_end: PID check fail / reserved PID
err_crc  output  1  status with pkt_end: CRC5/CRC16 residual mismatch
err_len  output  1  status with pkt_end: wrong byte count
err_rx  output  1  status with pkt_end: rx_error seen

Behaviour:
- Clock: one clock; reset is synchronous and active-high.
- Reset: all outputs 0, FSM IDLE, CRC regs all-ones, byte counter 0. Reset mid-packet drops packet, no pkt_end.
- FSM states: IDLE, PID, TOKEN, DATA, HSK, DRAIN, END.
- IDLE: rx_active rise -> PID.
- PID: first rx_valid: pid<=rx_data[3:0]. If rx_data[7:4] != ~rx_data[3:0] or PID reserved (0000) -> DRAIN with err_pid. Token/SOF -> TOKEN. DATA0/1/2/MDATA -> DATA. ACK/NAK/STALL/NYET -> HSK. PRE/ERR/SPLIT/PING: ping->TOKEN, others -> DRAIN err_pid.
- TOKEN: exactly 2 more bytes required. CRC5 (poly x^5+x^2+1, init 11111) over 16 bits; residual must be 01100. Byte1 = {endp[0],addr[6:0]}, byte2 = {crc5,endp[3:1]}; SOF frame_no = {byte2[2:0],byte1}. tok_addr/tok_endp/frame_no latched on byte2; tok_valid pulses 1 cycle after rx_active falls if count==2 and CRC ok.
- DATA: CRC16 (poly 0x8005, init FFFF) over all bytes after PID; residual must be 0x800D. Two-byte holdback pipeline: byte n emitted on pl_valid in the cycle after byte n+2 arrives; last 2 bytes never emitted. Fewer than 2 bytes after PID -> err_len. Payload count > MAX_PAYLOAD -> err_len, stop emitting.
- HSK: any byte after PID -> err_len.
- CRC per byte: one combinational 8-bit step, LSB first, on rx_valid.
- End: rx_active falling edge in any non-IDLE state -> END: one-cycle pkt_end with pkt_ok = ~(any err). Error flags hold until next PID state entry. DRAIN ignores bytes until rx_active low.
- rx_error at any time while active: set err_rx, -> DRAIN.
- rx_valid and rx_active fall same cycle: byte processed first, then end.
- rx_active low while in PID (no byte): pkt_end with err_len.
- pkt_end latency: 1 clk after rx_active falls.

Decomposition:
- Shared package types: pid_t enum (OUT=0001, IN=1001, SOF=0101, SETUP=1101, DATA0=0011, DATA1=1011, DATA2=0111, MDATA=1111, ACK=0010, NAK=1010, STALL=1110, NYET=0110, PRE/ERR=1100, SPLIT=1000, PING=0100), CRC5_RESIDUAL, CRC16_RESIDUAL, CRC polynomials.
- Sub-module usb_crc_byte: combinational next-CRC for CRC5 and CRC16 given current CRC and byte.

Test Plan:
- SETUP addr 0 endp 0: bytes 2D 00 10 -> tok_valid, tok_addr=0, tok_endp=0, pkt_end, pkt_ok=1.
- DATA0 zero-length: C3 00 00 -> no pl_valid, pkt_end, pkt_ok=1.
- DATA1 payload 01 02 03 + correct CRC16 from model -> pl_valid x3 with 01,02,03, pkt_ok=1; flip one CRC bit -> err_crc=1, pkt_ok=0.
- ACK D2 -> pkt_end, pkt_ok=1, pid=2; D2 followed by extra byte 00 -> err_len=1.
- Bad PID 2C -> err_pid=1, remaining bytes ignored, single pkt_end.
- rx_error mid DATA payload -> err_rx=1, pl_valid stops; reset asserted mid-packet -> no pkt_end, outputs 0.

Source files
------------

// File: rtl/usb_rx_pkt_pkg.sv
// Shared types and constants for the USB packet receive controller.
// PID encodings, FSM state encoding, CRC polynomials and good-packet residuals.
// Also holds the PID classifier used when the first byte of a packet arrives.
package usb_rx_pkt_pkg;

  typedef enum logic [3:0] {
    PID_RSVD  = 4'b0000,
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_DATA2 = 4'b0111,
    PID_MDATA = 4'b1111,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_NYET  = 4'b0110,
    PID_PRE   = 4'b1100,
    PID_SPLIT = 4'b1000,
    PID_PING  = 4'b0100
  } pid_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_TOKEN, ST_DATA, ST_HSK, ST_DRAIN, ST_END
  } state_t;

  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [4:0]  CRC5_INIT      = 5'b11111;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // Where a packet goes after its PID byte; bad complement or unsupported PIDs drain.
  function automatic state_t pid_dest(input logic [7:0] b);
    state_t d;
    d = ST_DRAIN;
    if (b[7:4] == ~b[3:0]) begin
      case (pid_t'(b[3:0]))
        PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_PING:   d = ST_TOKEN;
        PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA:      d = ST_DATA;
        PID_ACK, PID_NAK, PID_STALL, PID_NYET:           d = ST_HSK;
        default:                                         d = ST_DRAIN;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/usb_rx_pkt_crc.sv
// Combinational one-byte step of the USB CRC5 and CRC16 registers.
// Latency: zero (pure logic); bits consumed LSB first as they were on the wire.
// No flow control; the caller decides when to commit the result.
module usb_crc_byte
  import usb_rx_pkt_pkg::*;
(
  input  logic [4:0]  crc5_in,
  input  logic [15:0] crc16_in,
  input  logic [7:0]  data,
  output logic [4:0]  crc5_out,
  output logic [15:0] crc16_out
);

  // Eight serial shift steps unrolled: feedback is incoming bit xor register MSB.
  always_comb begin
    crc5_out  = crc5_in;
    crc16_out = crc16_in;
    for (int i = 0; i < 8; i++) begin
      if (data[i] ^ crc5_out[4]) crc5_out = {crc5_out[3:0], 1'b0} ^ CRC5_POLY;
      else                       crc5_out = {crc5_out[3:0], 1'b0};
      if (data[i] ^ crc16_out[15]) crc16_out = {crc16_out[14:0], 1'b0} ^ CRC16_POLY;
      else                         crc16_out = {crc16_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/usb_rx_pkt.sv
// Packet-level USB receive: PID check, token/SOF field extraction, DATA payload with CRC strip.
// Latency: payload byte n leaves one cycle after byte n+2 arrives; pkt_end one cycle after rx_active falls.
// No backpressure: the receiver byte stream is consumed as it arrives, outputs are single-cycle pulses.
module usb_rx_pkt
  import usb_rx_pkt_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_active,
  input  logic        rx_error,
  output logic [3:0]  pid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic [10:0] frame_no,
  output logic        tok_valid,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pkt_end,
  output logic        pkt_ok,
  output logic        err_pid,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_rx
);

  // Byte count after PID at which the next arriving byte would push payload past the limit.
  localparam logic [15:0] LEN_LIMIT = 16'(MAX_PAYLOAD + 2);

  state_t      state, state_d, dest, eff;
  logic        act_q;
  logic [4:0]  crc5, crc5_nx, crc5_after;
  logic [15:0] crc16, crc16_nx, crc16_after;
  logic [15:0] cnt, cnt_inc, cnt_after;
  logic [7:0]  hold0, hold1;
  logic        start_pkt, pid_load, tok_take, data_take, emit, go_end, tok_ok;
  logic        set_pid, set_crc, set_len, set_rx;

  usb_crc_byte u_crc (
    .crc5_in   (crc5),
    .crc16_in  (crc16),
    .data      (rx_data),
    .crc5_out  (crc5_nx),
    .crc16_out (crc16_nx)
  );

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next state and per-cycle strobes; a byte arriving with the rx_active fall is folded in before end checks.
  always_comb begin
    state_d     = state;
    start_pkt   = 1'b0;
    pid_load    = 1'b0;
    tok_take    = 1'b0;
    data_take   = 1'b0;
    emit        = 1'b0;
    go_end      = 1'b0;
    tok_ok      = 1'b0;
    set_pid     = 1'b0;
    set_crc     = 1'b0;
    set_len     = 1'b0;
    set_rx      = 1'b0;
    dest        = pid_dest(rx_data);
    eff         = state;
    cnt_after   = cnt;
    crc5_after  = crc5;
    crc16_after = crc16;
    case (state)
      ST_IDLE: if (rx_active && !act_q) begin
        state_d   = ST_PID;
        start_pkt = 1'b1;
      end
      ST_PID: begin
        if (rx_valid) begin
          pid_load = 1'b1;
          state_d  = dest;
          eff      = dest;
          set_pid  = (dest == ST_DRAIN);
        end else if (!rx_active) begin
          set_len = 1'b1;
        end
      end
      ST_TOKEN: if (rx_valid) begin
        tok_take   = 1'b1;
        cnt_after  = cnt_inc;
        crc5_after = crc5_nx;
      end
      ST_DATA: if (rx_valid) begin
        data_take   = 1'b1;
        cnt_after   = cnt_inc;
        crc16_after = crc16_nx;
        if (cnt >= 16'd2) begin
          if (cnt >= LEN_LIMIT) set_len = 1'b1;
          else                  emit    = 1'b1;
        end
      end
      ST_HSK: if (rx_valid) set_len = 1'b1;
      ST_END: state_d = ST_IDLE;
      default: ;
    endcase
    if (state != ST_IDLE && state != ST_END) begin
      if (rx_active && rx_error) begin
        state_d   = ST_DRAIN;
        set_rx    = 1'b1;
        pid_load  = 1'b0;
        tok_take  = 1'b0;
        data_take = 1'b0;
        emit      = 1'b0;
        set_pid   = 1'b0;
        set_len   = 1'b0;
      end else if (!rx_active) begin
        state_d = ST_END;
        go_end  = 1'b1;
        if (eff == ST_TOKEN) begin
          if (cnt_after != 16'd2)           set_len = 1'b1;
          if (crc5_after != CRC5_RESIDUAL)  set_crc = 1'b1;
          tok_ok = (cnt_after == 16'd2) && (crc5_after == CRC5_RESIDUAL);
        end
        if (eff == ST_DATA) begin
          if (cnt_after < 16'd2)              set_len = 1'b1;
          if (crc16_after != CRC16_RESIDUAL)  set_crc = 1'b1;
        end
      end
    end
  end

  // Datapath: CRC/count registers, two-byte holdback, field latches, sticky error flags and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q     <= 1'b1;  // a packet already in flight at reset is not mistaken for a new one
      crc5      <= CRC5_INIT;
      crc16     <= CRC16_INIT;
      cnt       <= 16'd0;
      hold0     <= 8'd0;
      hold1     <= 8'd0;
      pid       <= 4'd0;
      tok_addr  <= 7'd0;
      tok_endp  <= 4'd0;
      frame_no  <= 11'd0;
      tok_valid <= 1'b0;
      pl_data   <= 8'd0;
      pl_valid  <= 1'b0;
      pkt_end   <= 1'b0;
      pkt_ok    <= 1'b0;
      err_pid   <= 1'b0;
      err_crc   <= 1'b0;
      err_len   <= 1'b0;
      err_rx    <= 1'b0;
    end else begin
      act_q     <= rx_active;
      pkt_end   <= go_end;
      pkt_ok    <= go_end & ~(err_pid | err_crc | err_len | err_rx |
                              set_pid | set_crc | set_len | set_rx);
      tok_valid <= tok_ok;
      pl_valid  <= emit;
      if (emit) pl_data <= hold0;
      if (start_pkt) begin
        crc5    <= CRC5_INIT;
        crc16   <= CRC16_INIT;
        cnt     <= 16'd0;
        err_pid <= 1'b0;
        err_crc <= 1'b0;
        err_len <= 1'b0;
        err_rx  <= 1'b0;
      end else begin
        err_pid <= err_pid | set_pid;
        err_crc <= err_crc | set_crc;
        err_len <= err_len | set_len;
        err_rx  <= err_rx  | set_rx;
      end
      if (pid_load) pid <= rx_data[3:0];
      if (tok_take) begin
        crc5  <= crc5_nx;
        cnt   <= cnt_inc;
        hold1 <= rx_data;
        if (cnt == 16'd1) begin
          tok_addr <= hold1[6:0];
          tok_endp <= {rx_data[2:0], hold1[7]};
          frame_no <= {rx_data[2:0], hold1};
        end
      end
      if (data_take) begin
        crc16 <= crc16_nx;
        cnt   <= cnt_inc;
        hold0 <= hold1;
        hold1 <= rx_data;
      end
    end
  end

endmodule
